// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM,
// and a byte output held under a valid/rd_ack handshake with error pulses.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 521,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] data,
  output logic       valid,
  input  logic       rd_ack,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] HALF_M1 = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  data_n;
  logic        valid_n, ferr_n, ovr_n;
  logic        rx_meta, rx_s;

  // Synchroniser presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      data        <= data_n;
      valid       <= valid_n;
      framing_err <= ferr_n;
      overrun     <= ovr_n;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // otherwise paths that do not assign it would infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = data;
    valid_n   = valid & ~rd_ack;
    ferr_n    = 1'b0;
    ovr_n     = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == BIT_M1) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt == BIT_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            // A fresh byte beats a same-edge acknowledge of the old one.
            data_n  = shreg;
            valid_n = 1'b1;
            ovr_n   = valid & ~rd_ack;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus random bytes, all
// expectations taken from frame timing arithmetic and a byte/valid scoreboard.
module tb_uart_rx_deserializer;

  localparam int C   = 521;
  localparam int H   = C / 2;
  localparam int LAT = 2 + H + 9 * C;   // pin start edge to valid rising edge

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RX = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] data;
  logic       valid, busy, framing_err, overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  // Scoreboard: what the consumer should currently see.
  logic [7:0] m_data;
  logic       m_valid;

  uart_rx_deserializer #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .reset       (reset),
    .RX          (RX),
    .data        (data),
    .valid       (valid),
    .rd_ack      (rd_ack),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (framing_err) fe_cnt <= fe_cnt + 1;
    if (overrun)     ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    RX = v;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    RX = 1'b1;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack  = 1'b0;
    m_valid = 1'b0;
    check("ack_clears_valid", 32'(valid), 32'(m_valid));
  endtask

  // Checks the cycle before and the cycle after the expected completion edge.
  task automatic expect_frame(input int e0, input logic [7:0] b, input logic stop_ok,
                              input logic ack_edge);
    wait_cyc(e0 + LAT - 1);
    check("busy_in_frame", 32'(busy), 32'd1);
    if (!m_valid) check("valid_not_early", 32'(valid), 32'd0);
    if (ack_edge) rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("busy_after_stop", 32'(busy), 32'(!stop_ok));
    check("framing_err", 32'(framing_err), 32'(!stop_ok));
    check("overrun", 32'(overrun), 32'(stop_ok && m_valid && !ack_edge));
    if (stop_ok) begin
      m_data  = b;
      m_valid = 1'b1;
    end
    check("data", 32'(data), 32'(m_data));
    check("valid", 32'(valid), 32'(m_valid));
  endtask

  initial begin
    int e0, fe0, ov0;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    m_data  = 8'h00;
    m_valid = 1'b0;
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(framing_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle(5);

    // Basic frame with exact latency.
    e0 = cyc + 1;
    fork
      send_frame(8'hA5, 1'b1);
      expect_frame(e0, 8'hA5, 1'b1, 1'b0);
    join
    ack();
    idle(10);

    // Short low glitch must be rejected silently.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    RX = 1'b0;
    idle(100);
    RX = 1'b1;
    idle(2 * C);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_no_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    e0 = cyc + 1;
    fork
      send_frame(8'h3C, 1'b1);
      expect_frame(e0, 8'h3C, 1'b1, 1'b0);
    join
    ack();
    idle(10);

    // Bad stop bit followed by a long break: exactly one framing error.
    fe0 = fe_cnt;
    e0 = cyc + 1;
    fork
      begin
        send_frame(8'h81, 1'b0);
        RX = 1'b0;
        idle(3000);
        RX = 1'b1;
      end
      expect_frame(e0, 8'h81, 1'b0, 1'b0);
    join
    idle(C);
    check("break_one_ferr", 32'(fe_cnt - fe0), 32'd1);
    check("break_busy", 32'(busy), 32'd0);
    check("break_data_kept", 32'(data), 32'(m_data));
    e0 = cyc + 1;
    fork
      send_frame(8'h55, 1'b1);
      expect_frame(e0, 8'h55, 1'b1, 1'b0);
    join
    ack();
    idle(10);

    // Back-to-back without acknowledge: second byte overruns the first.
    ov0 = ov_cnt;
    e0 = cyc + 1;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        expect_frame(e0, 8'h11, 1'b1, 1'b0);
        expect_frame(e0 + 10 * C, 8'h22, 1'b1, 1'b0);
      end
    join
    idle(5);
    check("b2b_overrun_count", 32'(ov_cnt - ov0), 32'd1);

    // Same again with rd_ack on each completion edge: no overrun.
    ov0 = ov_cnt;
    e0 = cyc + 1;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        expect_frame(e0, 8'h11, 1'b1, 1'b1);
        expect_frame(e0 + 10 * C, 8'h22, 1'b1, 1'b1);
      end
    join
    idle(5);
    check("b2b_ack_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Reset in the middle of data bit 4; upper bits are 1 so the line goes quiet.
    b = {4'hF, 4'($urandom_range(0, 15))};
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    e0 = cyc + 1;
    fork
      send_frame(b, 1'b1);
      begin
        wait_cyc(e0 + 5 * C + C / 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_data  = 8'h00;
        m_valid = 1'b0;
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ferr", 32'(framing_err), 32'd0);
        check("midrst_ovr", 32'(overrun), 32'd0);
      end
    join
    idle(C);
    check("midrst_no_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    check("midrst_valid_low", 32'(valid), 32'd0);
    e0 = cyc + 1;
    fork
      send_frame(8'hF0, 1'b1);
      expect_frame(e0, 8'hF0, 1'b1, 1'b0);
    join

    // Random bytes, random gaps, random consumer acknowledges.
    for (int n = 0; n < 3; n++) begin
      if ($urandom_range(0, 1) == 1) ack();
      idle($urandom_range(1, 300));
      b  = 8'($urandom);
      e0 = cyc + 1;
      fork
        send_frame(b, 1'b1);
        expect_frame(e0, b, 1'b1, 1'b0);
      join
    end

    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-side stage directly downstream of the UART transmitter; consumes its serial TX line (wired to this block's RX) and recovers bytes.
- Fixed 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); line idles high.
- Mid-bit sampling with a per-bit clock-count timer; default timing is 9600 bps from a 5 MHz clock.
- Presents each byte to the consumer with a valid/ack handshake and flags framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 521, clock cycles per bit period (5 MHz / 9600 bps); legal range 4 to 65535.
- HALF_BIT, CLKS_PER_BIT/2 (260), cycles from the detected start edge to the start-bit mid-sample; integer division.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- RX  in  1  serial input, asynchronous to clk, idle high.
- data  out  8  last received byte; held until the next byte completes.
- valid  out  1  byte available; held high until acknowledged.
- rd_ack  in  1  consumer acknowledge; clears valid on the next edge.
- busy  out  1  high whenever FSM is not IDLE.
- framing_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: new byte completed while valid still high and rd_ack low.

Behaviour:
- Reset (reset=1 at a clk edge):
  - data=0, valid=0, busy=0, framing_err=0, overrun=0.
  - FSM=IDLE; counters and shift register cleared.
  - Synchroniser flops set to 1.
  - Applies mid-frame as well: the partial byte is discarded, with no error pulse.
- Input synchronisation: 2-flop synchroniser; rx_s is RX delayed 2 cycles. All FSM decisions use rx_s only.
- Bit-period timer cnt: 16-bit, counts 0..CLKS_PER_BIT-1 and wraps; cleared on every state change.
- FSM states:
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: when cnt==HALF_BIT-1, sample rx_s.
    - 0: go to DATA with cnt=0, bit_idx=0.
    - 1: glitch; return to IDLE with no flags.
  - DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx] (LSB first) and increment bit_idx. When bit_idx==7 is sampled, go to STOP.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1: on that edge load data<=shreg and set valid<=1. If valid was already 1 and rd_ack=0, pulse overrun (data is overwritten). Go to IDLE.
    - 0: pulse framing_err; data and valid are unchanged; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line therefore produces exactly one framing_err.
- Handshake:
  - rd_ack with valid=1 clears valid on the next edge.
  - If rd_ack=1 on the same edge a new byte completes, the new byte wins: valid stays 1, data updates, no overrun.
  - rd_ack while valid=0 is ignored.
- Latency: valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the RX falling edge at the pin. With defaults this is 4951 cycles.
- Back-to-back frames: IDLE is re-entered at the stop-bit mid-sample, so a start bit arriving immediately after the stop bit is detected.

Test Plan:
- Frame 0xA5 at 521 clk/bit → valid rises 4951 cycles after the start edge with data=0xA5; framing_err=0, overrun=0; busy low after.
- Low glitch on RX of 100 cycles from idle → FSM returns to IDLE; no valid and no error flags; next real frame 0x3C received correctly.
- Frame 0x81 with stop bit driven 0, RX then held low 3000 cycles → one framing_err pulse; valid stays 0; data keeps its prior value. Next frame 0x55 is received after RX returns high.
- Two back-to-back frames 0x11 then 0x22 with no rd_ack → data=0x22, valid=1, and one overrun pulse on the second completion. Repeat with rd_ack=1 on the completion edge → no overrun.
- reset asserted one cycle in the middle of data bit 4 of a frame → all outputs 0 next cycle. Remaining bits are treated as line activity; a clean subsequent frame 0xF0 is received correctly.
